// File: rtl/ifu_pkg.sv
// Shared constants and FSM state encoding for the instruction fetch unit.
package ifu_pkg;

  localparam int unsigned INST_W   = 32;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_e;

endpackage

// File: rtl/ifu_fetch.sv
// Single-outstanding instruction fetch unit: requests one word at a time,
// hands it to decode through a valid/ready register and follows redirects.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = ifu_pkg::RESET_PC,
  parameter int unsigned INST_W   = ifu_pkg::INST_W
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req,
  output logic [INST_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [INST_W-1:0] mem_rdata,
  input  logic              redirect_valid,
  input  logic [INST_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_pc,
  output logic [INST_W-1:0] out_inst
);

  import ifu_pkg::*;

  localparam logic [INST_W-1:0] PC_STEP    = INST_W'(4);
  localparam logic [INST_W-1:0] ALIGN_MASK = ~INST_W'(3);
  localparam logic [INST_W-1:0] PC_INIT    = INST_W'(RESET_PC);

  state_e            state_q, state_d;
  logic [INST_W-1:0] pc_q, pc_d;
  logic              drop_q, drop_d;
  logic              mem_req_q, mem_req_d;
  logic              out_valid_q, out_valid_d;
  logic [INST_W-1:0] out_pc_q, out_pc_d;
  logic [INST_W-1:0] out_inst_q, out_inst_d;
  logic [INST_W-1:0] redirect_target;

  // Redirect targets are word aligned by clearing the low two bits.
  assign redirect_target = redirect_pc & ALIGN_MASK;

  // State and registered output update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pc_q        <= PC_INIT;
      drop_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      out_inst_q  <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_q      <= drop_d;
      mem_req_q   <= mem_req_d;
      out_valid_q <= out_valid_d;
      out_pc_q    <= out_pc_d;
      out_inst_q  <= out_inst_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_d      = drop_q;
    out_valid_d = out_valid_q;
    out_pc_d    = out_pc_q;
    out_inst_d  = out_inst_q;

    case (state_q)
      IDLE: begin
        state_d = REQ;
        if (redirect_valid) pc_d = redirect_target;
      end

      REQ: begin
        if (redirect_valid) begin
          pc_d = redirect_target;
          // A granted request to the stale address must have its data dropped.
          if (mem_gnt) begin
            drop_d  = 1'b1;
            state_d = WAIT;
          end
        end else if (mem_gnt) begin
          state_d = WAIT;
        end
      end

      WAIT: begin
        if (mem_rvalid) begin
          if (redirect_valid) begin
            pc_d    = redirect_target;
            drop_d  = 1'b0;
            state_d = REQ;
          end else if (drop_q) begin
            drop_d  = 1'b0;
            state_d = REQ;
          end else begin
            out_inst_d  = mem_rdata;
            out_pc_d    = pc_q;
            out_valid_d = 1'b1;
            pc_d        = pc_q + PC_STEP;
            state_d     = HOLD;
          end
        end else if (redirect_valid) begin
          pc_d   = redirect_target;
          drop_d = 1'b1;
        end
      end

      HOLD: begin
        if (redirect_valid) begin
          pc_d        = redirect_target;
          out_valid_d = 1'b0;
          state_d     = REQ;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = REQ;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign mem_req_d = (state_d == REQ);

  assign mem_req   = mem_req_q;
  assign mem_addr  = pc_q;
  assign out_valid = out_valid_q;
  assign out_pc    = out_pc_q;
  assign out_inst  = out_inst_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Scenario bench for ifu_fetch: scripted memory responses, expected words
// queued when returned data is driven and compared when decode sees them.
module tb_ifu_fetch;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk;
  logic        rst_n;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;

  ifu_fetch dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_gnt       (mem_gnt),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_inst      (out_inst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_gnt        = 1'b0;
    mem_rvalid     = 1'b0;
    mem_rdata      = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
  endtask

  // Leaves the DUT in its first REQ cycle at the reset PC.
  task automatic do_reset();
    idle_inputs();
    out_ready = 1'b1;
    rst_n     = 1'b0;
    sb.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    out_ready = 1'b1;
    rst_n     = 1'b0;
    tick();
    checks++; if (mem_req !== 1'b0) $display("FAIL rst_mem_req: got %b want 0", mem_req); else passes++;
    checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid); else passes++;
    checks++; if (out_pc !== 32'h0) $display("FAIL rst_out_pc: got %h want 0", out_pc); else passes++;
    checks++; if (out_inst !== 32'h0) $display("FAIL rst_out_inst: got %h want 0", out_inst); else passes++;
    checks++; if (mem_addr !== RST_PC) $display("FAIL rst_mem_addr: got %h want %h", mem_addr, RST_PC); else passes++;
    rst_n = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b0) $display("FAIL idle_mem_req: got %b want 0", mem_req); else passes++;
    tick();
    checks++; if (mem_req !== 1'b1) $display("FAIL first_req: got %b want 1", mem_req); else passes++;
    checks++; if (mem_addr !== RST_PC) $display("FAIL first_addr: got %h want %h", mem_addr, RST_PC); else passes++;
  endtask

  task automatic test_basic_fetch();
    exp_t e;
    do_reset();
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    checks++; if (mem_req !== 1'b0) $display("FAIL wait_mem_req: got %b want 0", mem_req); else passes++;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0050_0313;
    sb.push_back('{pc: RST_PC, inst: 32'h0050_0313});
    tick();
    mem_rvalid = 1'b0;
    checks++; if (out_valid !== 1'b1) $display("FAIL basic_valid: got %b want 1", out_valid); else passes++;
    e = sb.pop_front();
    checks++; if (out_pc !== e.pc) $display("FAIL basic_pc: got %h want %h", out_pc, e.pc); else passes++;
    checks++; if (out_inst !== e.inst) $display("FAIL basic_inst: got %h want %h", out_inst, e.inst); else passes++;
    tick();
    checks++; if (out_valid !== 1'b0) $display("FAIL basic_valid_clr: got %b want 0", out_valid); else passes++;
    checks++; if (mem_req !== 1'b1) $display("FAIL basic_next_req: got %b want 1", mem_req); else passes++;
    checks++; if (mem_addr !== 32'h8000_0004) $display("FAIL basic_next_addr: got %h want 80000004", mem_addr); else passes++;
  endtask

  task automatic test_backpressure();
    exp_t e;
    do_reset();
    out_ready = 1'b0;
    mem_gnt   = 1'b1;
    tick();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h00A0_0093;
    sb.push_back('{pc: RST_PC, inst: 32'h00A0_0093});
    tick();
    mem_rvalid = 1'b0;
    e = sb.pop_front();
    for (int i = 0; i < 5; i++) begin
      checks++; if (out_valid !== 1'b1) $display("FAIL bp_valid[%0d]: got %b want 1", i, out_valid); else passes++;
      checks++; if (out_pc !== e.pc) $display("FAIL bp_pc[%0d]: got %h want %h", i, out_pc, e.pc); else passes++;
      checks++; if (out_inst !== e.inst) $display("FAIL bp_inst[%0d]: got %h want %h", i, out_inst, e.inst); else passes++;
      checks++; if (mem_req !== 1'b0) $display("FAIL bp_mem_req[%0d]: got %b want 0", i, mem_req); else passes++;
      // Stray rvalid in HOLD must not disturb the held word.
      mem_rvalid = (i == 2);
      mem_rdata  = 32'hBAD0_BAD0;
      tick();
    end
    mem_rvalid = 1'b0;
    out_ready  = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) $display("FAIL bp_release_valid: got %b want 0", out_valid); else passes++;
    checks++; if (mem_req !== 1'b1) $display("FAIL bp_release_req: got %b want 1", mem_req); else passes++;
    checks++; if (mem_addr !== 32'h8000_0004) $display("FAIL bp_release_addr: got %h want 80000004", mem_addr); else passes++;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (mem_req !== 1'b1) $display("FAIL b2b_req[%0d]: got %b want 1", i, mem_req); else passes++;
      checks++; if (mem_addr !== RST_PC + 32'(4 * i)) $display("FAIL b2b_addr[%0d]: got %h want %h", i, mem_addr, RST_PC + 32'(4 * i)); else passes++;
      checks++; if (out_valid !== 1'b0) $display("FAIL b2b_idle_valid[%0d]: got %b want 0", i, out_valid); else passes++;
      mem_gnt = 1'b1;
      tick();
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h1000_0000 + 32'(i);
      sb.push_back('{pc: RST_PC + 32'(4 * i), inst: 32'h1000_0000 + 32'(i)});
      tick();
      mem_rvalid = 1'b0;
      checks++; if (out_valid !== 1'b1) $display("FAIL b2b_valid[%0d]: got %b want 1", i, out_valid); else passes++;
      e = sb.pop_front();
      checks++; if (out_pc !== e.pc) $display("FAIL b2b_pc[%0d]: got %h want %h", i, out_pc, e.pc); else passes++;
      checks++; if (out_inst !== e.inst) $display("FAIL b2b_inst[%0d]: got %h want %h", i, out_inst, e.inst); else passes++;
      tick();
    end
  endtask

  task automatic test_redirect_wait();
    exp_t e;
    do_reset();
    mem_gnt = 1'b1;
    tick();
    mem_gnt        = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0103;
    tick();
    redirect_valid = 1'b0;
    mem_rvalid     = 1'b1;
    mem_rdata      = 32'hDEAD_BEEF;
    tick();
    mem_rvalid = 1'b0;
    checks++; if (out_valid !== 1'b0) $display("FAIL rw_drop_valid: got %b want 0", out_valid); else passes++;
    checks++; if (mem_req !== 1'b1) $display("FAIL rw_req: got %b want 1", mem_req); else passes++;
    checks++; if (mem_addr !== 32'h8000_0100) $display("FAIL rw_addr: got %h want 80000100", mem_addr); else passes++;
    mem_gnt = 1'b1;
    tick();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0000_0013;
    sb.push_back('{pc: 32'h8000_0100, inst: 32'h0000_0013});
    tick();
    mem_rvalid = 1'b0;
    e = sb.pop_front();
    checks++; if (out_valid !== 1'b1) $display("FAIL rw_refetch_valid: got %b want 1", out_valid); else passes++;
    checks++; if (out_pc !== e.pc) $display("FAIL rw_refetch_pc: got %h want %h", out_pc, e.pc); else passes++;
    checks++; if (out_inst !== e.inst) $display("FAIL rw_refetch_inst: got %h want %h", out_inst, e.inst); else passes++;
  endtask

  task automatic test_redirect_req();
    do_reset();
    // Cycle 1 and 2: no grant, address held.
    checks++; if (mem_addr !== RST_PC) $display("FAIL rq_addr_c1: got %h want %h", mem_addr, RST_PC); else passes++;
    tick();
    checks++; if (mem_addr !== RST_PC) $display("FAIL rq_addr_c2: got %h want %h", mem_addr, RST_PC); else passes++;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0040;
    tick();
    redirect_valid = 1'b0;
    checks++; if (mem_req !== 1'b1) $display("FAIL rq_req_c3: got %b want 1", mem_req); else passes++;
    checks++; if (mem_addr !== 32'h8000_0040) $display("FAIL rq_addr_c3: got %h want 80000040", mem_addr); else passes++;
    tick();
    checks++; if (mem_addr !== 32'h8000_0040) $display("FAIL rq_addr_c4: got %h want 80000040", mem_addr); else passes++;
    // Redirect coincident with grant: the in-flight word must be dropped.
    mem_gnt        = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_1002;
    tick();
    mem_gnt        = 1'b0;
    redirect_valid = 1'b0;
    checks++; if (mem_req !== 1'b0) $display("FAIL rq_gnt_wait: got %b want 0", mem_req); else passes++;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hCAFE_F00D;
    tick();
    mem_rvalid = 1'b0;
    checks++; if (out_valid !== 1'b0) $display("FAIL rq_gnt_drop: got %b want 0", out_valid); else passes++;
    checks++; if (mem_addr !== 32'h0000_1000) $display("FAIL rq_gnt_addr: got %h want 00001000", mem_addr); else passes++;
  endtask

  task automatic test_redirect_rvalid_hold();
    exp_t e;
    do_reset();
    // Redirect together with rvalid in WAIT: data discarded, no drop pending.
    mem_gnt = 1'b1;
    tick();
    mem_gnt        = 1'b0;
    mem_rvalid     = 1'b1;
    mem_rdata      = 32'h1111_1111;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0300;
    tick();
    mem_rvalid     = 1'b0;
    redirect_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) $display("FAIL rr_valid: got %b want 0", out_valid); else passes++;
    checks++; if (mem_addr !== 32'h8000_0300) $display("FAIL rr_addr: got %h want 80000300", mem_addr); else passes++;
    out_ready = 1'b0;
    mem_gnt   = 1'b1;
    tick();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h2222_2222;
    sb.push_back('{pc: 32'h8000_0300, inst: 32'h2222_2222});
    tick();
    mem_rvalid = 1'b0;
    e = sb.pop_front();
    checks++; if (out_pc !== e.pc) $display("FAIL rr_fetch_pc: got %h want %h", out_pc, e.pc); else passes++;
    checks++; if (out_inst !== e.inst) $display("FAIL rr_fetch_inst: got %h want %h", out_inst, e.inst); else passes++;
    // Redirect in HOLD.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0200;
    tick();
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    checks++; if (out_valid !== 1'b0) $display("FAIL rh_valid: got %b want 0", out_valid); else passes++;
    checks++; if (mem_req !== 1'b1) $display("FAIL rh_req: got %b want 1", mem_req); else passes++;
    checks++; if (mem_addr !== 32'h8000_0200) $display("FAIL rh_addr: got %h want 80000200", mem_addr); else passes++;
  endtask

  task automatic test_wrap();
    exp_t e;
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    checks++; if (mem_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_req_addr: got %h want fffffffc", mem_addr); else passes++;
    mem_gnt = 1'b1;
    tick();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0000_006F;
    sb.push_back('{pc: 32'hFFFF_FFFC, inst: 32'h0000_006F});
    tick();
    mem_rvalid = 1'b0;
    e = sb.pop_front();
    checks++; if (out_pc !== e.pc) $display("FAIL wrap_pc: got %h want %h", out_pc, e.pc); else passes++;
    checks++; if (out_inst !== e.inst) $display("FAIL wrap_inst: got %h want %h", out_inst, e.inst); else passes++;
    tick();
    checks++; if (mem_addr !== 32'h0000_0000) $display("FAIL wrap_next_addr: got %h want 00000000", mem_addr); else passes++;
  endtask

  task automatic test_reset_mid();
    exp_t e;
    // Asynchronous assertion clears a held word without a clock edge.
    do_reset();
    out_ready = 1'b0;
    mem_gnt   = 1'b1;
    tick();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h3333_3333;
    tick();
    mem_rvalid = 1'b0;
    checks++; if (out_valid !== 1'b1) $display("FAIL rm_hold_valid: got %b want 1", out_valid); else passes++;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL rm_async_valid: got %b want 0", out_valid); else passes++;
    checks++; if (out_inst !== 32'h0) $display("FAIL rm_async_inst: got %h want 0", out_inst); else passes++;
    tick();
    // Reset in WAIT, late rvalid after release.
    do_reset();
    out_ready = 1'b1;
    mem_gnt   = 1'b1;
    tick();
    mem_gnt = 1'b0;
    rst_n   = 1'b0;
    tick();
    rst_n      = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hBAD_C0DE0;
    tick();
    checks++; if (out_valid !== 1'b0) $display("FAIL rm_late_valid: got %b want 0", out_valid); else passes++;
    checks++; if (mem_req !== 1'b1) $display("FAIL rm_req: got %b want 1", mem_req); else passes++;
    checks++; if (mem_addr !== RST_PC) $display("FAIL rm_addr: got %h want %h", mem_addr, RST_PC); else passes++;
    tick();
    mem_rvalid = 1'b0;
    checks++; if (out_valid !== 1'b0) $display("FAIL rm_req_rvalid: got %b want 0", out_valid); else passes++;
    mem_gnt = 1'b1;
    tick();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h4444_4444;
    sb.push_back('{pc: RST_PC, inst: 32'h4444_4444});
    tick();
    mem_rvalid = 1'b0;
    e = sb.pop_front();
    checks++; if (out_pc !== e.pc) $display("FAIL rm_fetch_pc: got %h want %h", out_pc, e.pc); else passes++;
    checks++; if (out_inst !== e.inst) $display("FAIL rm_fetch_inst: got %h want %h", out_inst, e.inst); else passes++;
  endtask

  initial begin
    idle_inputs();
    out_ready = 1'b1;
    rst_n     = 1'b0;
    test_reset();
    test_basic_fetch();
    test_backpressure();
    test_back_to_back();
    test_redirect_wait();
    test_redirect_req();
    test_redirect_rvalid_hold();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
